alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Hardwired Moore control unit that sequences the datapath through instruction fetch and execute steps.
- Replaces the per-test hand-driven T0..Tn strobe waveforms.
- Covers register-register ALU ops, immediate ALU ops, mul/div (HI/LO), neg/not, nop and halt.
- Sits beside the datapath: reads IR, drives every datapath strobe, and addresses registers via Gra/Grb/Grc select lines.

Parameters:
- RESET_PC_HOLD, 1, number of idle cycles after reset release before the first T0 (range 1..3).

Ports:
- Clock  in  1  system clock; all state updates on its rising edge
- Reset  in  1  asynchronous, active-high reset
- Stop  in  1  level; request halt at the next instruction boundary
- IR  in  32  instruction register contents; opcode = IR[31:27]
- Gra, Grb, Grc  out  1 each  select Ra/Rb/Rc field as the register address
- Rin, Rout  out  1 each  write/read strobe for the selected register
- PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Cout  out  1 each  bus drivers
- PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin  out  1 each  register loads
- IncPC, Read  out  1 each  PC increment; memory read into MDR
- ALU_op  out  5  ALU operation code
- Run  out  1  high while executing; low once halted
- Illegal  out  1  one-cycle pulse on decode of an unlisted opcode

Behaviour:
- Reset asserted (any time, including mid-instruction):
  - state = RST; all strobes 0; ALU_op = 0; Run = 1; Illegal = 0.
  - Release: stay in RST for RESET_PC_HOLD cycles, then go to T0.
- Outputs are pure decode of (state, IR[31:27]); each strobe is held high for the whole cycle, so the datapath loads on the closing edge.
- Fetch (every instruction):
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin.
  - T2: MDRout, IRin.
  - T2 -> T3.
- Opcode encodings, and the ALU_op each class drives:
  - add 00011, sub 00100, and 00101, or 00110, shr 00111, shra 01000, shl 01001, ror 01010, rol 01011.
  - addi 01100, andi 01101, ori 01110.
  - mul 01111, div 10000, neg 10001, not 10010.
  - nop 11010, halt 11011.
- Reg-reg (add..rol, mul, div):
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, Zin; ALU_op = opcode.
  - add..rol, T5: Zlowout, Gra, Rin; then T0.
  - mul/div, T5: Zlowout, LOin. T6: Zhighout, HIin. Then T0.
- Immediate (addi/andi/ori):
  - T3: Grb, Rout, Yin.
  - T4: Cout, Zin; ALU_op = add/and/or code (00011/00101/00110).
  - T5: Zlowout, Gra, Rin; then T0.
- Unary (neg/not):
  - T3: Grc, Rout, Zin; ALU_op = opcode.
  - T4: Zlowout, Gra, Rin; then T0.
- nop: T3 drives no strobes; then T0.
- halt: T3 -> HALT. Run = 0; no strobes; HALT is left only by Reset.
- Unlisted opcode: T3 pulses Illegal for one cycle, drives no strobes; then T0 (treated as nop).
- Stop:
  - Sampled only in the last execute state of an instruction.
  - If high there, next state = HALT instead of T0; the current instruction completes.
  - Stop high during fetch has no effect until that point.
- ALU_op holds its value only in the states listed above; it is 0 everywhere else.
- At most one bus driver is high in any state. This is an invariant and is checked by assertion.
- Latency: 6 cycles (T0..T5) for reg-reg and immediate ops; 7 for mul/div; 5 for neg/not; 4 for nop.

Decomposition:
- Shared package cpu_pkg:
  - opcode localparams;
  - state encoding RST, T0..T6, HALT (4-bit);
  - IR field bit positions.
- One sub-module, seq_decode: purely combinational (state, opcode) -> strobe vector. It is kept separate so verification can exhaustively check the one-bus-driver rule.
- The top holds the state register, reset hold counter and Stop sampling.

Test Plan:
- Reset pulse mid-T4 of an add:
  - all strobes drop asynchronously; Run = 1;
  - after release plus RESET_PC_HOLD = 1 cycle, the state is T0 with PCout = MARin = IncPC = Zin = 1.
- IR = 0x28918000 (and R1, R2, R3):
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, Zin, ALU_op = 00101.
  - T5: Gra, Rin, Zlowout.
  - Next cycle is T0.
- IR opcode 01111 (mul):
  - T5 asserts Zlowout and LOin.
  - T6 asserts Zhighout and HIin.
  - Gra/Rin is never asserted; 7 cycles T0..T6, then T0.
- IR opcode 01100 (addi):
  - T4 asserts Cout, Zin, ALU_op = 00011.
  - T5 writes Ra.
- Stop raised in T1 of a sub:
  - the instruction completes through T5 with Gra/Rin;
  - next state is HALT; Run = 0 and stays 0 until Reset.
- IR opcode 11111:
  - Illegal = 1 in T3 only; no strobes;
  - next state is T0; Run remains 1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the hardwired control unit: opcodes, FSM states,
// IR field positions and the strobe bundle produced by the decoder.
package cpu_pkg;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RA_LSB  = 23;
  localparam int RB_LSB  = 19;
  localparam int RC_LSB  = 15;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [3:0] ST_RST  = 4'd0;
  localparam logic [3:0] ST_T0   = 4'd1;
  localparam logic [3:0] ST_T1   = 4'd2;
  localparam logic [3:0] ST_T2   = 4'd3;
  localparam logic [3:0] ST_T3   = 4'd4;
  localparam logic [3:0] ST_T4   = 4'd5;
  localparam logic [3:0] ST_T5   = 4'd6;
  localparam logic [3:0] ST_T6   = 4'd7;
  localparam logic [3:0] ST_HALT = 4'd8;

  typedef struct packed {
    logic gra, grb, grc, rin, rout;
    logic pcout, zhighout, zlowout, mdrout, hiout, loout, cout;
    logic pcin, marin, mdrin, irin, yin, zin, hiin, loin;
    logic incpc, read;
    logic [4:0] alu_op;
    logic run, illegal;
  } strobe_t;

  function automatic logic is_regreg(input logic [4:0] op);
    return (op >= OP_ADD) && (op <= OP_ROL);
  endfunction

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic is_imm(input logic [4:0] op);
    return (op >= OP_ADDI) && (op <= OP_ORI);
  endfunction

  function automatic logic is_unary(input logic [4:0] op);
    return (op == OP_NEG) || (op == OP_NOT);
  endfunction

  // Immediate forms reuse the ALU code of their register-register sibling.
  function automatic logic [4:0] imm_alu_op(input logic [4:0] op);
    case (op)
      OP_ADDI: return OP_ADD;
      OP_ANDI: return OP_AND;
      default: return OP_OR;
    endcase
  endfunction

endpackage

// File: rtl/seq_decode.sv
// Combinational (state, opcode) -> strobe decode; also flags the final
// execute step of the current instruction so the top knows the boundary.
module seq_decode
  import cpu_pkg::*;
(
  input  logic [3:0] state,
  input  logic [4:0] opcode,
  output strobe_t    strb,
  output logic       last
);

  always_comb begin
    strb     = '0;
    strb.run = 1'b1;
    last     = 1'b0;
    case (state)
      ST_T0: begin
        strb.pcout = 1'b1; strb.marin = 1'b1; strb.incpc = 1'b1; strb.zin = 1'b1;
      end
      ST_T1: begin
        strb.zlowout = 1'b1; strb.pcin = 1'b1; strb.read = 1'b1; strb.mdrin = 1'b1;
      end
      ST_T2: begin
        strb.mdrout = 1'b1; strb.irin = 1'b1;
      end
      ST_T3: begin
        if (is_regreg(opcode) || is_muldiv(opcode) || is_imm(opcode)) begin
          strb.grb = 1'b1; strb.rout = 1'b1; strb.yin = 1'b1;
        end else if (is_unary(opcode)) begin
          strb.grc = 1'b1; strb.rout = 1'b1; strb.zin = 1'b1; strb.alu_op = opcode;
        end else if (opcode != OP_HALT) begin
          // nop and unlisted opcodes both end here; only the latter flags Illegal
          strb.illegal = (opcode != OP_NOP);
          last         = 1'b1;
        end
      end
      ST_T4: begin
        if (is_regreg(opcode) || is_muldiv(opcode)) begin
          strb.grc = 1'b1; strb.rout = 1'b1; strb.zin = 1'b1; strb.alu_op = opcode;
        end else if (is_imm(opcode)) begin
          strb.cout = 1'b1; strb.zin = 1'b1; strb.alu_op = imm_alu_op(opcode);
        end else begin
          strb.zlowout = 1'b1; strb.gra = 1'b1; strb.rin = 1'b1;
          last         = 1'b1;
        end
      end
      ST_T5: begin
        if (is_muldiv(opcode)) begin
          strb.zlowout = 1'b1; strb.loin = 1'b1;
        end else begin
          strb.zlowout = 1'b1; strb.gra = 1'b1; strb.rin = 1'b1;
          last         = 1'b1;
        end
      end
      ST_T6: begin
        strb.zhighout = 1'b1; strb.hiin = 1'b1;
        last          = 1'b1;
      end
      ST_HALT: strb.run = 1'b0;
      default: strb.run = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Hardwired Moore control unit: state register, post-reset hold counter and
// Stop sampling at instruction boundaries; strobes come from seq_decode.
module alu_sequencer
  import cpu_pkg::*;
#(
  parameter int RESET_PC_HOLD = 1
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Stop,
  input  logic [31:0] IR,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        PCout,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        HIout,
  output logic        LOout,
  output logic        Cout,
  output logic        PCin,
  output logic        MARin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        HIin,
  output logic        LOin,
  output logic        IncPC,
  output logic        Read,
  output logic [4:0]  ALU_op,
  output logic        Run,
  output logic        Illegal
);

  localparam logic [1:0] HOLD_LAST = 2'(RESET_PC_HOLD - 1);

  logic [3:0] state_q, state_d;
  logic [1:0] hold_q, hold_d;
  logic [4:0] opcode;
  logic       last;
  logic       unused_ir;
  strobe_t    strb;

  assign opcode    = IR[OPC_MSB:OPC_LSB];
  assign unused_ir = ^IR[OPC_LSB-1:0];

  seq_decode u_decode (
    .state  (state_q),
    .opcode (opcode),
    .strb   (strb),
    .last   (last)
  );

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      ST_RST: begin
        if (hold_q == HOLD_LAST) begin
          state_d = ST_T0;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + 2'd1;
        end
      end
      ST_T0, ST_T1, ST_T2: state_d = state_q + 4'd1;
      ST_T3, ST_T4, ST_T5, ST_T6: begin
        if ((state_q == ST_T3) && (opcode == OP_HALT)) state_d = ST_HALT;
        else if (last) state_d = Stop ? ST_HALT : ST_T0;
        else state_d = state_q + 4'd1;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_RST;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_RST;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  assign Gra      = strb.gra;
  assign Grb      = strb.grb;
  assign Grc      = strb.grc;
  assign Rin      = strb.rin;
  assign Rout     = strb.rout;
  assign PCout    = strb.pcout;
  assign Zhighout = strb.zhighout;
  assign Zlowout  = strb.zlowout;
  assign MDRout   = strb.mdrout;
  assign HIout    = strb.hiout;
  assign LOout    = strb.loout;
  assign Cout     = strb.cout;
  assign PCin     = strb.pcin;
  assign MARin    = strb.marin;
  assign MDRin    = strb.mdrin;
  assign IRin     = strb.irin;
  assign Yin      = strb.yin;
  assign Zin      = strb.zin;
  assign HIin     = strb.hiin;
  assign LOin     = strb.loin;
  assign IncPC    = strb.incpc;
  assign Read     = strb.read;
  assign ALU_op   = strb.alu_op;
  assign Run      = strb.run;
  assign Illegal  = strb.illegal;

  a_one_bus_driver: assert property (@(posedge Clock) disable iff (Reset)
    $onehot0({PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Cout}));

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized and directed bench for alu_sequencer against a micro-step model.
module tb_alu_sequencer;

  localparam int HOLD = 1;

  logic        Clock = 1'b0;
  logic        Reset, Stop;
  logic [31:0] IR;
  logic Gra, Grb, Grc, Rin, Rout, PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Cout;
  logic PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, IncPC, Read, Run, Illegal;
  logic [4:0] ALU_op;

  alu_sequencer #(.RESET_PC_HOLD(HOLD)) dut (
    .Clock(Clock), .Reset(Reset), .Stop(Stop), .IR(IR),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout), .Cout(Cout),
    .PCin(PCin), .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .HIin(HIin), .LOin(LOin), .IncPC(IncPC), .Read(Read),
    .ALU_op(ALU_op), .Run(Run), .Illegal(Illegal)
  );

  always #5 Clock = ~Clock;

  wire [28:0] obs = {Illegal, Run, ALU_op, Gra, Grb, Grc, Rin, Rout, PCout, Zhighout,
                     Zlowout, MDRout, HIout, LOout, Cout, PCin, MARin, MDRin, IRin,
                     Yin, Zin, HIin, LOin, IncPC, Read};
  wire [6:0]  bus = {PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Cout};

  localparam logic [28:0] M_READ = 29'd1 << 0,  M_INCPC = 29'd1 << 1,  M_LOIN = 29'd1 << 2;
  localparam logic [28:0] M_HIIN = 29'd1 << 3,  M_ZIN = 29'd1 << 4,    M_YIN = 29'd1 << 5;
  localparam logic [28:0] M_IRIN = 29'd1 << 6,  M_MDRIN = 29'd1 << 7,  M_MARIN = 29'd1 << 8;
  localparam logic [28:0] M_PCIN = 29'd1 << 9,  M_COUT = 29'd1 << 10,  M_MDROUT = 29'd1 << 13;
  localparam logic [28:0] M_ZLO = 29'd1 << 14,  M_ZHI = 29'd1 << 15,   M_PCOUT = 29'd1 << 16;
  localparam logic [28:0] M_ROUT = 29'd1 << 17, M_RIN = 29'd1 << 18,   M_GRC = 29'd1 << 19;
  localparam logic [28:0] M_GRB = 29'd1 << 20,  M_GRA = 29'd1 << 21;
  localparam logic [28:0] M_RUN = 29'd1 << 27,  M_ILL = 29'd1 << 28;

  int compared = 0;
  int mismatched = 0;
  logic [28:0] exp_q[$];
  logic [4:0]  ops[16];

  function automatic logic [28:0] alu(input logic [4:0] c);
    return {2'b00, c, 22'd0};
  endfunction

  task automatic check(input string tag, input logic [28:0] o, input logic [28:0] e);
    compared++;
    assert (o === e) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic check_bus(input string tag);
    compared++;
    assert ($onehot0(bus) === 1'b1) else begin
      mismatched++;
      $error("FAIL %s.bus: observed drivers %b expected at most one", tag, bus);
    end
  endtask

  // Micro-step list for one instruction, straight from the opcode class rules.
  task automatic build(input logic [4:0] op, output bit halts);
    logic [28:0] wr;
    halts = 1'b0;
    wr = M_RUN | M_ZLO | M_GRA | M_RIN;
    exp_q.push_back(M_RUN | M_PCOUT | M_MARIN | M_INCPC | M_ZIN);
    exp_q.push_back(M_RUN | M_ZLO | M_PCIN | M_READ | M_MDRIN);
    exp_q.push_back(M_RUN | M_MDROUT | M_IRIN);
    if ((op >= 5'd3 && op <= 5'd11) || op == 5'd15 || op == 5'd16) begin
      exp_q.push_back(M_RUN | M_GRB | M_ROUT | M_YIN);
      exp_q.push_back(M_RUN | M_GRC | M_ROUT | M_ZIN | alu(op));
      if (op == 5'd15 || op == 5'd16) begin
        exp_q.push_back(M_RUN | M_ZLO | M_LOIN);
        exp_q.push_back(M_RUN | M_ZHI | M_HIIN);
      end else begin
        exp_q.push_back(wr);
      end
    end else if (op >= 5'd12 && op <= 5'd14) begin
      exp_q.push_back(M_RUN | M_GRB | M_ROUT | M_YIN);
      exp_q.push_back(M_RUN | M_COUT | M_ZIN |
                      alu(op == 5'd12 ? 5'd3 : (op == 5'd13 ? 5'd5 : 5'd6)));
      exp_q.push_back(wr);
    end else if (op == 5'd17 || op == 5'd18) begin
      exp_q.push_back(M_RUN | M_GRC | M_ROUT | M_ZIN | alu(op));
      exp_q.push_back(wr);
    end else if (op == 5'd26) begin
      exp_q.push_back(M_RUN);
    end else if (op == 5'd27) begin
      exp_q.push_back(M_RUN);
      halts = 1'b1;
    end else begin
      exp_q.push_back(M_RUN | M_ILL);
    end
  endtask

  // Starts just before the negedge of T0. IR is applied during T0 so the
  // previous instruction's final decode is never disturbed.
  task automatic run_instr(input string tag, input logic [31:0] ir, input int stop_idx,
                           input int abort_idx, output bit halted);
    bit h;
    int n;
    exp_q.delete();
    build(ir[31:27], h);
    n = exp_q.size();
    halted = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge Clock);
      check($sformatf("%s.c%0d", tag, i), obs, exp_q[i]);
      check_bus(tag);
      if (i == 0) IR = ir;
      if (i == stop_idx) Stop = 1'b1;
      if (i == abort_idx) return;
    end
    halted = h || (stop_idx >= 0 && stop_idx < n);
    if (halted) begin
      for (int k = 0; k < 3; k++) begin
        @(negedge Clock);
        check($sformatf("%s.halt%0d", tag, k), obs, 29'd0);
      end
    end
  endtask

  task automatic do_reset(input string tag);
    #2 Reset = 1'b1;
    #1 check({tag, ".async"}, obs, M_RUN);
    Stop = 1'b0;
    @(posedge Clock);
    @(negedge Clock);
    check({tag, ".held"}, obs, M_RUN);
    Reset = 1'b0;
    #1 check({tag, ".rel"}, obs, M_RUN);
    for (int i = 1; i < HOLD; i++) begin
      @(negedge Clock);
      check({tag, ".hold"}, obs, M_RUN);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish within 50000 cycles");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit h;
    logic [4:0] op;
    int r;
    ops = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11,
            5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd17, 5'd18};
    Reset = 1'b1;
    Stop  = 1'b0;
    IR    = 32'd0;
    @(negedge Clock);
    check("reset_state", obs, M_RUN);
    @(negedge Clock);
    Reset = 1'b0;
    #1 check("release", obs, M_RUN);
    for (int i = 1; i < HOLD; i++) begin
      @(negedge Clock);
      check("release.hold", obs, M_RUN);
    end

    run_instr("add_abort", 32'h1891_8000, -1, 4, h);
    do_reset("rst_mid_t4");
    run_instr("and", 32'h2891_8000, -1, -1, h);
    run_instr("mul", 32'h7800_0000, -1, -1, h);
    run_instr("div", 32'h8012_3456, -1, -1, h);
    run_instr("addi", 32'h6000_0000, -1, -1, h);
    run_instr("andi", 32'h6800_0005, -1, -1, h);
    run_instr("ori", 32'h7000_0007, -1, -1, h);
    run_instr("neg", 32'h8800_0000, -1, -1, h);
    run_instr("not", 32'h9000_0000, -1, -1, h);
    run_instr("nop", 32'hD000_0000, -1, -1, h);
    run_instr("illegal", 32'hF800_0000, -1, -1, h);
    run_instr("after_ill", 32'h2000_0000, -1, -1, h);
    run_instr("sub_stop", 32'h2000_0000, 1, -1, h);
    do_reset("rst_after_stop");
    run_instr("halt", 32'hD800_0000, -1, -1, h);
    do_reset("rst_after_halt");

    for (int t = 0; t < 40; t++) begin
      r = int'($urandom_range(0, 19));
      if (r < 16) op = ops[r];
      else if (r < 19) op = 5'($urandom_range(0, 31));
      else op = 5'd27;
      run_instr($sformatf("rnd%0d_op%0d", t, op), {op, 27'($urandom)},
                ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1, -1, h);
      if (h) do_reset($sformatf("rnd%0d_rst", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
